// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD receiver.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR,
        BUSY
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CHAR_SPACE    = 8'h20;

    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] AC_WRAP1   = 7'h27;
    localparam logic [6:0] AC_WRAP2   = 7'h67;

    // Address counter step after a data write: end of line 1 jumps to line 2,
    // end of line 2 wraps to the start of line 1.
    function automatic logic [6:0] ac_next(input logic [6:0] ac);
        if (ac == AC_WRAP1) begin
            return LINE2_BASE;
        end else if (ac == AC_WRAP2) begin
            return '0;
        end else begin
            return ac + 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_rx_sync.sv
// Two-flop synchronizers for the LCD bus and E edge detection.
module lcd_rx_sync (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [3:0] LCD_D,
    output logic       rs_s,
    output logic       rw_s,
    output logic [3:0] d_s,
    output logic       eRise,
    output logic       eFall
);

    logic       e_meta_q, e_sync_q, e_prev_q;
    logic       rs_meta_q, rs_sync_q;
    logic       rw_meta_q, rw_sync_q;
    logic [3:0] d_meta_q, d_sync_q;

    // Synchronizer chains plus one extra E stage for edge detection
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            e_meta_q  <= 1'b0;
            e_sync_q  <= 1'b0;
            e_prev_q  <= 1'b0;
            rs_meta_q <= 1'b0;
            rs_sync_q <= 1'b0;
            rw_meta_q <= 1'b0;
            rw_sync_q <= 1'b0;
            d_meta_q  <= '0;
            d_sync_q  <= '0;
        end else begin
            e_meta_q  <= LCD_E;
            e_sync_q  <= e_meta_q;
            e_prev_q  <= e_sync_q;
            rs_meta_q <= LCD_RS;
            rs_sync_q <= rs_meta_q;
            rw_meta_q <= LCD_RW;
            rw_sync_q <= rw_meta_q;
            d_meta_q  <= LCD_D;
            d_sync_q  <= d_meta_q;
        end
    end

    assign rs_s  = rs_sync_q;
    assign rw_s  = rw_sync_q;
    assign d_s   = d_sync_q;
    assign eRise = e_sync_q & ~e_prev_q;
    assign eFall = ~e_sync_q & e_prev_q;

endmodule

// File: rtl/lcd_receive_text.sv
// LCD bus responder: reassembles nibbles, executes address/clear commands,
// keeps a 2-line character buffer. Optional readback: LCD_RX_READBACK_EN.
module lcd_receive_text
    import lcd_pkg::*;
#(
    parameter int LINE_LENGTH = 16,
    parameter int BUSY_CYCLES = 2000
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     LCD_E,
    input  logic                     LCD_RS,
    input  logic                     LCD_RW,
    inout  wire logic [3:0]          LCD_D,
    output logic [8*LINE_LENGTH-1:0] line1,
    output logic [8*LINE_LENGTH-1:0] line2,
    output logic                     byteValid,
    output logic [7:0]               byteData,
    output logic                     byteRs,
    output logic                     busy,
    output logic                     errBusy
);

    localparam int IDX_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int CLR_W = $clog2(2 * LINE_LENGTH);
    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);
`ifdef LCD_RX_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic       rs_s, rw_s, e_rise, e_fall;
    logic [3:0] d_s;

    lcd_rx_sync u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .LCD_E (LCD_E),
        .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW),
        .LCD_D (LCD_D),
        .rs_s  (rs_s),
        .rw_s  (rw_s),
        .d_s   (d_s),
        .eRise (e_rise),
        .eFall (e_fall)
    );

    lcd_state_t       state_q, state_d;
    logic [6:0]       ac_q, ac_d;
    logic             phase_lo_q, phase_lo_d;
    logic [3:0]       hi_nib_q, hi_nib_d;
    logic             rs_lat_q, rs_lat_d, rw_lat_q, rw_lat_d;
    logic             rw_first_q, rw_first_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_rs_q, byte_rs_d;
    logic             busy_q, busy_d;
    logic             err_busy_q, err_busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CLR_W-1:0] clr_idx_q, clr_idx_d;
    logic [7:0]       line1_q [LINE_LENGTH];
    logic [7:0]       line1_d [LINE_LENGTH];
    logic [7:0]       line2_q [LINE_LENGTH];
    logic [7:0]       line2_d [LINE_LENGTH];

    // Bus decode, byte acceptance and the command/data execution FSM
    always_comb begin
        state_d      = state_q;
        ac_d         = ac_q;
        phase_lo_d   = phase_lo_q;
        hi_nib_d     = hi_nib_q;
        rs_lat_d     = rs_lat_q;
        rw_lat_d     = rw_lat_q;
        rw_first_d   = rw_first_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        byte_rs_d    = byte_rs_q;
        err_busy_d   = 1'b0;
        cnt_d        = cnt_q;
        clr_idx_d    = clr_idx_q;
        line1_d      = line1_q;
        line2_d      = line2_q;

        if (e_rise) begin
            rs_lat_d = rs_s;
            rw_lat_d = rw_s;
        end

        // Read pulses only take part in the pair phase when readback exists
        if (e_fall && (READBACK || !rw_lat_q)) begin
            if (!phase_lo_q) begin
                hi_nib_d   = d_s;
                rw_first_d = rw_lat_q;
                phase_lo_d = 1'b1;
            end else begin
                phase_lo_d = 1'b0;
                if (rw_first_q != rw_lat_q) begin
                    err_busy_d = 1'b1;
                end else if (!rw_lat_q) begin
                    if (busy_q || byte_valid_q) begin
                        err_busy_d = 1'b1;
                    end else begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = {hi_nib_q, d_s};
                        byte_rs_d    = rs_lat_q;
                    end
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (byte_valid_q) state_d = EXEC;
            end
            EXEC: begin
                cnt_d     = '0;
                clr_idx_d = '0;
                state_d   = BUSY;
                if (byte_rs_q) begin
                    if (ac_q < 7'(LINE_LENGTH)) begin
                        line1_d[IDX_W'(ac_q)] = byte_data_q;
                    end else if (ac_q >= LINE2_BASE && ac_q < LINE2_BASE + 7'(LINE_LENGTH)) begin
                        line2_d[IDX_W'(ac_q - LINE2_BASE)] = byte_data_q;
                    end
                    ac_d = ac_next(ac_q);
                end else if ((byte_data_q & CMD_SET_DDRAM) != '0) begin
                    ac_d = byte_data_q[6:0];
                end else if (byte_data_q == CMD_CLEAR) begin
                    ac_d    = '0;
                    state_d = CLEAR;
                end else if (byte_data_q[7:1] == CMD_HOME[7:1]) begin
                    ac_d = '0;
                end
            end
            CLEAR: begin
                if (clr_idx_q < CLR_W'(LINE_LENGTH)) begin
                    line1_d[IDX_W'(clr_idx_q)] = CHAR_SPACE;
                end else begin
                    line2_d[IDX_W'(clr_idx_q - CLR_W'(LINE_LENGTH))] = CHAR_SPACE;
                end
                if (clr_idx_q == CLR_W'(2 * LINE_LENGTH - 1)) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(BUSY_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            ac_q         <= '0;
            phase_lo_q   <= 1'b0;
            hi_nib_q     <= '0;
            rs_lat_q     <= 1'b0;
            rw_lat_q     <= 1'b0;
            rw_first_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            byte_rs_q    <= 1'b0;
            busy_q       <= 1'b0;
            err_busy_q   <= 1'b0;
            cnt_q        <= '0;
            clr_idx_q    <= '0;
            line1_q      <= '{default: CHAR_SPACE};
            line2_q      <= '{default: CHAR_SPACE};
        end else begin
            state_q      <= state_d;
            ac_q         <= ac_d;
            phase_lo_q   <= phase_lo_d;
            hi_nib_q     <= hi_nib_d;
            rs_lat_q     <= rs_lat_d;
            rw_lat_q     <= rw_lat_d;
            rw_first_q   <= rw_first_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_rs_q    <= byte_rs_d;
            busy_q       <= busy_d;
            err_busy_q   <= err_busy_d;
            cnt_q        <= cnt_d;
            clr_idx_q    <= clr_idx_d;
            line1_q      <= line1_d;
            line2_q      <= line2_d;
        end
    end

    // Pack the buffers with character 0 in the most significant byte
    always_comb begin
        line1 = '0;
        line2 = '0;
        for (int unsigned i = 0; i < LINE_LENGTH; i++) begin
            line1[(LINE_LENGTH - 1 - i) * 8 +: 8] = line1_q[i];
            line2[(LINE_LENGTH - 1 - i) * 8 +: 8] = line2_q[i];
        end
    end

    assign byteValid = byte_valid_q;
    assign byteData  = byte_data_q;
    assign byteRs    = byte_rs_q;
    assign busy      = busy_q;
    assign errBusy   = err_busy_q;

`ifdef LCD_RX_READBACK_EN
    logic       drive_q, drive_d;
    logic [3:0] rd_q, rd_d;

    // Readback driver: status/AC nibble chosen at E rise, released after E fall
    always_comb begin
        drive_d = drive_q;
        rd_d    = rd_q;
        if (e_rise) begin
            drive_d = rw_s;
            rd_d    = phase_lo_q ? ac_q[3:0] : {busy_q, ac_q[6:4]};
        end else if (e_fall) begin
            drive_d = 1'b0;
        end
    end

    // Readback registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            drive_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            drive_q <= drive_d;
            rd_q    <= rd_d;
        end
    end

    assign LCD_D = drive_q ? rd_q : 4'bz;
`else
    assign LCD_D = 4'bz;
`endif

endmodule
